regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_wb_arbiter.sv | 166 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port owner: post-reset clear, then ALU/load writeback arbitration
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_waddr,
  input  logic [XLEN-1:0] alu_wdata,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [AW-1:0]   ld_waddr,
  input  logic [XLEN-1:0] ld_wdata,
  output logic            ld_ready,
  output logic            RegWrite,
  output logic [AW-1:0]   waddr,
  output logic [XLEN-1:0] wdata,
  output logic            init_done,
  output logic [NREG-1:0] busy_mask
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;
  typedef enum logic [1:0] {LL_NONE, LL_ALU, LL_LD} loser_t;

  state_t          state_q, state_d;
  loser_t          last_loser_q, last_loser_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            regwrite_q, regwrite_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            init_done_q, init_done_d;
  logic [NREG-1:0] busy_q, busy_d;

  logic            hold_alu_v_q, hold_alu_v_d;
  logic [AW-1:0]   hold_alu_addr_q, hold_alu_addr_d;
  logic [XLEN-1:0] hold_alu_data_q, hold_alu_data_d;
  logic            hold_ld_v_q, hold_ld_v_d;
  logic [AW-1:0]   hold_ld_addr_q, hold_ld_addr_d;
  logic [XLEN-1:0] hold_ld_data_q, hold_ld_data_d;

  logic            alu_take, ld_take;
  logic            alu_cand, ld_cand, contested, ld_wins, alu_wins;
  logic [AW-1:0]   alu_addr_c, ld_addr_c;
  logic [XLEN-1:0] alu_data_c, ld_data_c;

  assign alu_ready = init_done_q & ~hold_alu_v_q;
  assign ld_ready  = init_done_q & ~hold_ld_v_q;

  // Writes to x0 are accepted (handshake completes) but never become candidates.
  assign alu_take = alu_valid & alu_ready & (alu_waddr != '0);
  assign ld_take  = ld_valid  & ld_ready  & (ld_waddr  != '0);

  assign alu_cand   = hold_alu_v_q | alu_take;
  assign ld_cand    = hold_ld_v_q  | ld_take;
  assign alu_addr_c = hold_alu_v_q ? hold_alu_addr_q : alu_waddr;
  assign alu_data_c = hold_alu_v_q ? hold_alu_data_q : alu_wdata;
  assign ld_addr_c  = hold_ld_v_q  ? hold_ld_addr_q  : ld_waddr;
  assign ld_data_c  = hold_ld_v_q  ? hold_ld_data_q  : ld_wdata;

  assign contested = alu_cand & ld_cand;
  // Load is the older instruction, so it wins same-address ties and the uncontested-history default.
  assign ld_wins  = ld_cand & (~alu_cand | (alu_addr_c == ld_addr_c) | (last_loser_q != LL_ALU));
  assign alu_wins = alu_cand & ~ld_wins;

  always_comb begin
    state_d         = state_q;
    last_loser_d    = last_loser_q;
    cnt_d           = cnt_q;
    regwrite_d      = 1'b0;
    waddr_d         = waddr_q;
    wdata_d         = wdata_q;
    init_done_d     = init_done_q;
    hold_alu_v_d    = hold_alu_v_q;
    hold_alu_addr_d = hold_alu_addr_q;
    hold_alu_data_d = hold_alu_data_q;
    hold_ld_v_d     = hold_ld_v_q;
    hold_ld_addr_d  = hold_ld_addr_q;
    hold_ld_data_d  = hold_ld_data_q;
    busy_d          = '0;

    case (state_q)
      S_CLEAR: begin
        regwrite_d = 1'b1;
        waddr_d    = cnt_q;
        wdata_d    = '0;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == AW'(NREG - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        init_done_d = 1'b1;
        if (ld_wins) begin
          regwrite_d  = 1'b1;
          waddr_d     = ld_addr_c;
          wdata_d     = ld_data_c;
          hold_ld_v_d = 1'b0;
          if (alu_take) begin
            hold_alu_v_d    = 1'b1;
            hold_alu_addr_d = alu_waddr;
            hold_alu_data_d = alu_wdata;
          end
          if (contested) last_loser_d = LL_ALU;
        end else if (alu_wins) begin
          regwrite_d   = 1'b1;
          waddr_d      = alu_addr_c;
          wdata_d      = alu_data_c;
          hold_alu_v_d = 1'b0;
          if (ld_take) begin
            hold_ld_v_d    = 1'b1;
            hold_ld_addr_d = ld_waddr;
            hold_ld_data_d = ld_wdata;
          end
          if (contested) last_loser_d = LL_LD;
        end
      end
      default: state_d = S_CLEAR;
    endcase

    for (int i = 0; i < NREG; i++) begin
      busy_d[i] = (hold_alu_v_d && (hold_alu_addr_d == AW'(i))) ||
                  (hold_ld_v_d  && (hold_ld_addr_d  == AW'(i)));
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q         <= S_CLEAR;
      last_loser_q    <= LL_NONE;
      cnt_q           <= '0;
      regwrite_q      <= 1'b0;
      waddr_q         <= '0;
      wdata_q         <= '0;
      init_done_q     <= 1'b0;
      busy_q          <= '0;
      hold_alu_v_q    <= 1'b0;
      hold_alu_addr_q <= '0;
      hold_alu_data_q <= '0;
      hold_ld_v_q     <= 1'b0;
      hold_ld_addr_q  <= '0;
      hold_ld_data_q  <= '0;
    end else begin
      state_q         <= state_d;
      last_loser_q    <= last_loser_d;
      cnt_q           <= cnt_d;
      regwrite_q      <= regwrite_d;
      waddr_q         <= waddr_d;
      wdata_q         <= wdata_d;
      init_done_q     <= init_done_d;
      busy_q          <= busy_d;
      hold_alu_v_q    <= hold_alu_v_d;
      hold_alu_addr_q <= hold_alu_addr_d;
      hold_alu_data_q <= hold_alu_data_d;
      hold_ld_v_q     <= hold_ld_v_d;
      hold_ld_addr_q  <= hold_ld_addr_d;
      hold_ld_data_q  <= hold_ld_data_d;
    end
  end

  assign RegWrite  = regwrite_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign init_done = init_done_q;
  assign busy_mask = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        alu_valid, ld_valid;
  logic [4:0]  alu_waddr, ld_waddr;
  logic [31:0] alu_wdata, ld_wdata;
  logic        alu_ready, ld_ready;
  logic        RegWrite;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        init_done;
  logic [31:0] busy_mask;

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] sb[$];

  regfile_wb_arbiter #(.XLEN(32), .NREG(32), .AW(5)) dut (
    .Clk(Clk), .Reset(Reset),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata), .ld_ready(ld_ready),
    .RegWrite(RegWrite), .waddr(waddr), .wdata(wdata),
    .init_done(init_done), .busy_mask(busy_mask)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
    sb.push_back({a, d});
  endtask

  // Advance one edge, sample 1ns later, and retire any register-file write against the scoreboard.
  task automatic tick();
    logic [36:0] e;
    @(posedge Clk);
    #1;
    if (RegWrite === 1'b1) begin
      n_checks++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_write: observed waddr %0d wdata %0h expected no write", waddr, wdata);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wb_addr", 32'(waddr), 32'(e[36:32]));
        chk("wb_data", wdata, e[31:0]);
      end
    end
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  task automatic drive_alu(input logic [4:0] a, input logic [31:0] d);
    alu_valid = 1'b1; alu_waddr = a; alu_wdata = d;
  endtask

  task automatic drive_ld(input logic [4:0] a, input logic [31:0] d);
    ld_valid = 1'b1; ld_waddr = a; ld_wdata = d;
  endtask

  task automatic run_clear();
    for (int i = 0; i < 32; i++) push_exp(5'(i), 32'h0);
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("clr_regwrite", 32'(RegWrite), 32'd1);
      chk("clr_init_done", 32'(init_done), 32'd0);
      chk("clr_readies", {30'd0, alu_ready, ld_ready}, 32'd0);
    end
    tick();
    chk("post_clr_regwrite", 32'(RegWrite), 32'd0);
    chk("post_clr_init_done", 32'(init_done), 32'd1);
    chk("post_clr_readies", {30'd0, alu_ready, ld_ready}, 32'd3);
    chk("post_clr_busy", busy_mask, 32'h0);
  endtask

  initial begin
    Reset = 1'b1;
    alu_valid = 1'b0; alu_waddr = '0; alu_wdata = '0;
    ld_valid  = 1'b0; ld_waddr  = '0; ld_wdata  = '0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_regwrite", 32'(RegWrite), 32'd0);
      chk("rst_waddr", 32'(waddr), 32'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);
      chk("rst_busy", busy_mask, 32'd0);
      chk("rst_readies", {30'd0, alu_ready, ld_ready}, 32'd0);
    end
    Reset = 1'b0;
    run_clear();

    // single ALU write
    drive_alu(5'd5, 32'hDEADBEEF); push_exp(5'd5, 32'hDEADBEEF);
    tick(); idle();
    chk("single_regwrite", 32'(RegWrite), 32'd1);
    chk("single_busy", busy_mask, 32'h0);

    // distinct-address contention, no history: ld first
    drive_ld(5'd3, 32'h11); drive_alu(5'd7, 32'h22);
    push_exp(5'd3, 32'h11); push_exp(5'd7, 32'h22);
    tick(); idle();
    chk("cont_busy_r7", busy_mask, 32'h0000_0080);
    chk("cont_alu_ready", 32'(alu_ready), 32'd0);
    chk("cont_ld_ready", 32'(ld_ready), 32'd1);
    tick();
    chk("cont_drain_regwrite", 32'(RegWrite), 32'd1);
    chk("cont_drain_busy", busy_mask, 32'h0);
    chk("cont_drain_alu_ready", 32'(alu_ready), 32'd1);

    // alu lost last time, so alu wins this one and ld becomes last loser
    drive_ld(5'd4, 32'h44); drive_alu(5'd6, 32'h66);
    push_exp(5'd6, 32'h66); push_exp(5'd4, 32'h44);
    tick(); idle();
    chk("rr_busy_r4", busy_mask, 32'h0000_0010);
    chk("rr_ld_ready", 32'(ld_ready), 32'd0);
    tick();
    chk("rr_drain_busy", busy_mask, 32'h0);

    // same address with last_loser=ld: ld still wins
    drive_ld(5'd9, 32'hAAAA); drive_alu(5'd9, 32'hBBBB);
    push_exp(5'd9, 32'hAAAA); push_exp(5'd9, 32'hBBBB);
    tick(); idle();
    chk("same_busy_r9", busy_mask, 32'h0000_0200);
    tick();
    chk("same_drain_busy", busy_mask, 32'h0);

    // x0 write is accepted and dropped
    chk("x0_alu_ready", 32'(alu_ready), 32'd1);
    drive_alu(5'd0, 32'h123);
    tick(); idle();
    chk("x0_no_regwrite", 32'(RegWrite), 32'd0);
    chk("x0_busy", busy_mask, 32'h0);
    chk("x0_alu_ready_after", 32'(alu_ready), 32'd1);

    // make ld the last loser before the fairness stream
    drive_ld(5'd10, 32'hA0); drive_alu(5'd11, 32'hB0);
    push_exp(5'd11, 32'hB0); push_exp(5'd10, 32'hA0);
    tick(); idle();
    tick();

    // streaming: grants ld, alu, ld, alu, then drain ld
    push_exp(5'd12, 32'hC1); push_exp(5'd13, 32'hD1);
    push_exp(5'd14, 32'hC2); push_exp(5'd15, 32'hD3); push_exp(5'd16, 32'hC4);
    drive_ld(5'd12, 32'hC1); drive_alu(5'd13, 32'hD1);
    tick(); idle();
    chk("fair1_readies", {30'd0, alu_ready, ld_ready}, 32'd1);
    drive_ld(5'd14, 32'hC2);
    tick(); idle();
    chk("fair2_readies", {30'd0, alu_ready, ld_ready}, 32'd2);
    drive_alu(5'd15, 32'hD3);
    tick(); idle();
    chk("fair3_readies", {30'd0, alu_ready, ld_ready}, 32'd1);
    drive_ld(5'd16, 32'hC4);
    tick(); idle();
    chk("fair4_busy", busy_mask, 32'h0001_0000);
    tick();
    chk("fair_drain_regwrite", 32'(RegWrite), 32'd1);
    chk("fair_drain_busy", busy_mask, 32'h0);

    // reset while hold_alu is occupied
    drive_ld(5'd20, 32'hE0); drive_alu(5'd21, 32'hF0);
    push_exp(5'd20, 32'hE0);
    tick(); idle();
    chk("pre_rst_busy_r21", busy_mask, 32'h0020_0000);
    Reset = 1'b1;
    tick();
    chk("midrst_regwrite", 32'(RegWrite), 32'd0);
    chk("midrst_busy", busy_mask, 32'h0);
    chk("midrst_init_done", 32'(init_done), 32'd0);
    chk("midrst_readies", {30'd0, alu_ready, ld_ready}, 32'd0);
    tick();
    Reset = 1'b0;
    run_clear();
    tick();
    chk("final_regwrite", 32'(RegWrite), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
